// File: rtl/puf_pkg.sv
// Shared types and constants for the PUF response streamer.
// HD_APPEND_EN adds the Hamming-distance byte to every frame.
package puf_pkg;

    typedef logic [7:0] byte_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SYNC,
        ST_INDEX,
        ST_DATA,
        ST_HD,
        ST_CSUM
    } stream_state_t;

    localparam byte_t SYNC_BYTE_DEF = 8'hA5;
    localparam int    RESP_W_DEF    = 128;
    localparam int    IDX_W_DEF     = 8;

`ifdef HD_APPEND_EN
    localparam int FRAME_OVERHEAD = 4;
`else
    localparam int FRAME_OVERHEAD = 3;
`endif

    function automatic int frame_len(input int resp_w);
        return resp_w / 8 + FRAME_OVERHEAD;
    endfunction

endpackage

// File: rtl/puf_response_streamer_if.sv
// Response-capture and byte-stream handshakes of the PUF response streamer.
// The streamer is the slave; the response source and UART TX side form the master.
interface puf_response_streamer_if
    import puf_pkg::*;
#(
    parameter int RESP_W = RESP_W_DEF
) ();

    logic              resp_valid;
    logic              resp_ready;
    logic [RESP_W-1:0] resp_data;
    logic              tx_valid;
    logic              tx_ready;
    byte_t             tx_data;

    modport master (
        output resp_valid,
        output resp_data,
        output tx_ready,
        input  resp_ready,
        input  tx_valid,
        input  tx_data
    );

    modport slave (
        input  resp_valid,
        input  resp_data,
        input  tx_ready,
        output resp_ready,
        output tx_valid,
        output tx_data
    );

endinterface

// File: rtl/byte_popcount.sv
// Combinational 8-bit population count feeding the Hamming-distance accumulator.
// Only present when HD_APPEND_EN is defined.
`ifdef HD_APPEND_EN
module byte_popcount
    import puf_pkg::*;
(
    input  byte_t      i_byte,
    output logic [3:0] o_count
);

    always_comb begin
        o_count = '0;
        for (int i = 0; i < 8; i++) begin
            o_count = o_count + {3'b000, i_byte[i]};
        end
    end

endmodule
`endif

// File: rtl/puf_response_streamer.sv
// Captures PUF responses and streams each as a framed byte sequence toward the UART TX.
// HD_APPEND_EN inserts a Hamming-distance byte (vs. previous response) before the checksum.
//
// state    | meaning
// ST_IDLE  | ready for a response, no byte offered
// ST_SYNC  | offering the sync marker
// ST_INDEX | offering the frame index
// ST_DATA  | offering response bytes, MSB first
// ST_HD    | offering the Hamming distance byte
// ST_CSUM  | offering the XOR checksum; completes the frame
module puf_response_streamer
    import puf_pkg::*;
#(
    parameter int    RESP_W    = RESP_W_DEF,
    parameter byte_t SYNC_BYTE = SYNC_BYTE_DEF,
    parameter int    IDX_W     = IDX_W_DEF
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    puf_response_streamer_if.slave bus,
    output logic                  o_busy,
    output logic [IDX_W-1:0]      o_frame_cnt
);

    localparam int N_BYTES = RESP_W / 8;
    localparam int CNT_W   = (N_BYTES > 1) ? $clog2(N_BYTES) : 1;
    localparam logic [CNT_W-1:0] LAST_BYTE = CNT_W'(N_BYTES - 1);

    stream_state_t     r_state;
    stream_state_t     w_state_next;
    logic [RESP_W-1:0] r_resp;
    byte_t             r_idx;
    byte_t             r_csum;
    logic [CNT_W-1:0]  r_byte_cnt;
    logic [IDX_W-1:0]  r_frame_cnt;

    logic  w_capture;
    logic  w_tx_fire;
    logic  w_tx_valid;
    logic  w_resp_ready;
    byte_t w_tx_data;
    byte_t w_data_byte;

`ifdef HD_APPEND_EN
    logic [RESP_W-1:0] r_prev;
    byte_t             r_hd_acc;
    logic [3:0]        w_pop;

    byte_popcount u_popcount (
        .i_byte  (w_data_byte ^ r_prev[RESP_W-1 -: 8]),
        .o_count (w_pop)
    );
`endif

    // Response register rotates one byte per DATA transfer, so the current byte is always on top
    // and the full response is back in place once the frame reaches CSUM.
    assign w_data_byte = r_resp[RESP_W-1 -: 8];
    assign w_capture   = bus.resp_valid && w_resp_ready;
    assign w_tx_fire   = w_tx_valid && bus.tx_ready;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_tx_valid   = 1'b0;
        w_tx_data    = '0;
        w_resp_ready = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_resp_ready = 1'b1;
                if (bus.resp_valid) begin
                    w_state_next = ST_SYNC;
                end
            end
            ST_SYNC: begin
                w_tx_valid = 1'b1;
                w_tx_data  = SYNC_BYTE;
                if (bus.tx_ready) begin
                    w_state_next = ST_INDEX;
                end
            end
            ST_INDEX: begin
                w_tx_valid = 1'b1;
                w_tx_data  = r_idx;
                if (bus.tx_ready) begin
                    w_state_next = ST_DATA;
                end
            end
            ST_DATA: begin
                w_tx_valid = 1'b1;
                w_tx_data  = w_data_byte;
                if (bus.tx_ready && (r_byte_cnt == LAST_BYTE)) begin
`ifdef HD_APPEND_EN
                    w_state_next = ST_HD;
`else
                    w_state_next = ST_CSUM;
`endif
                end
            end
`ifdef HD_APPEND_EN
            ST_HD: begin
                w_tx_valid = 1'b1;
                w_tx_data  = r_hd_acc;
                if (bus.tx_ready) begin
                    w_state_next = ST_CSUM;
                end
            end
`endif
            ST_CSUM: begin
                w_tx_valid = 1'b1;
                w_tx_data  = r_csum;
                if (bus.tx_ready) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_resp      <= '0;
            r_idx       <= '0;
            r_csum      <= '0;
            r_byte_cnt  <= '0;
            r_frame_cnt <= '0;
`ifdef HD_APPEND_EN
            r_prev      <= '0;
            r_hd_acc    <= '0;
`endif
        end else begin
            if (w_capture) begin
                r_resp     <= bus.resp_data;
                r_idx      <= byte_t'(r_frame_cnt);
                r_csum     <= '0;
                r_byte_cnt <= '0;
`ifdef HD_APPEND_EN
                r_hd_acc   <= '0;
`endif
            end
            if (w_tx_fire) begin
                case (r_state)
                    ST_INDEX: begin
                        r_csum <= r_csum ^ r_idx;
                    end
                    ST_DATA: begin
                        r_csum     <= r_csum ^ w_data_byte;
                        r_resp     <= {r_resp[RESP_W-9:0], w_data_byte};
                        r_byte_cnt <= r_byte_cnt + CNT_W'(1);
`ifdef HD_APPEND_EN
                        r_prev     <= {r_prev[RESP_W-9:0], r_prev[RESP_W-1 -: 8]};
                        r_hd_acc   <= r_hd_acc + {4'b0000, w_pop};
`endif
                    end
`ifdef HD_APPEND_EN
                    ST_HD: begin
                        r_csum <= r_csum ^ r_hd_acc;
                    end
`endif
                    ST_CSUM: begin
                        r_frame_cnt <= r_frame_cnt + IDX_W'(1);
`ifdef HD_APPEND_EN
                        r_prev      <= r_resp;
`endif
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    assign bus.resp_ready = w_resp_ready;
    assign bus.tx_valid   = w_tx_valid;
    assign bus.tx_data    = w_tx_data;
    assign o_busy         = (r_state != ST_IDLE);
    assign o_frame_cnt    = r_frame_cnt;

endmodule

// File: tb/tb_puf_response_streamer.sv
// Self-checking bench for puf_response_streamer; frames are predicted from the frame format rules.
// Build with or without HD_APPEND_EN.
module tb_puf_response_streamer;
    import puf_pkg::*;

    localparam int RESP_W = 128;
    localparam int NB     = RESP_W / 8;
`ifdef HD_APPEND_EN
    localparam int EXP_LEN = NB + 4;
`else
    localparam int EXP_LEN = NB + 3;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       busy;
    logic [7:0] frame_cnt;

    always #5 clk = ~clk;

    puf_response_streamer_if #(.RESP_W(RESP_W)) bus_if ();

    puf_response_streamer #(
        .RESP_W    (RESP_W),
        .SYNC_BYTE (8'hA5),
        .IDX_W     (8)
    ) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .bus         (bus_if),
        .o_busy      (busy),
        .o_frame_cnt (frame_cnt)
    );

    int                n_checks = 0;
    int                n_pass   = 0;
    byte_t             mon_q[$];
    int                m_frame_cnt = 0;
    logic [RESP_W-1:0] m_prev = '0;

    always @(posedge clk) begin
        if (!rst && bus_if.tx_valid && bus_if.tx_ready) mon_q.push_back(bus_if.tx_data);
    end

    // Expected frame from the format rules: sync, index, bytes MSB first, [HD], XOR checksum.
    task automatic model_frame(input logic [RESP_W-1:0] resp, output byte_t q[$]);
        byte_t csum, idx, b;
        q = {};
        idx = byte_t'(m_frame_cnt % 256);
        q.push_back(8'hA5);
        q.push_back(idx);
        csum = idx;
        for (int k = 0; k < NB; k++) begin
            b = resp[RESP_W-1-8*k -: 8];
            q.push_back(b);
            csum ^= b;
        end
`ifdef HD_APPEND_EN
        begin
            int hd;
            hd = $countones(resp ^ m_prev);
            q.push_back(byte_t'(hd));
            csum ^= byte_t'(hd);
        end
`endif
        q.push_back(csum);
    endtask

    task automatic commit(input logic [RESP_W-1:0] resp);
        m_frame_cnt = (m_frame_cnt + 1) % 256;
        m_prev      = resp;
    endtask

    task automatic model_reset();
        m_frame_cnt = 0;
        m_prev      = '0;
    endtask

    function automatic logic [RESP_W-1:0] rand_resp();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic offer(input logic [RESP_W-1:0] resp, output bit ok);
        int n = 0;
        bus_if.resp_data  = resp;
        bus_if.resp_valid = 1'b1;
        while (!bus_if.resp_ready && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        ok = bus_if.resp_ready;
        @(posedge clk); #1;
        bus_if.resp_valid = 1'b0;
    endtask

    task automatic collect(input int want, input bit rnd, output bit ok);
        int    n = 0;
        bit    pv, pr;
        byte_t pd;
        while (mon_q.size() < want && n < 2000) begin
            bus_if.tx_ready = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
            pv = bus_if.tx_valid;
            pr = bus_if.tx_ready;
            pd = bus_if.tx_data;
            @(posedge clk); #1;
            n++;
            if (pv && !pr) begin
                n_checks++;
                if (bus_if.tx_valid !== 1'b1 || bus_if.tx_data !== pd)
                    $display("FAIL stall_hold got valid=%b data=%h exp valid=1 data=%h",
                             bus_if.tx_valid, bus_if.tx_data, pd);
                else n_pass++;
            end
        end
        ok = (mon_q.size() >= want);
    endtask

    task automatic check_frame(input string name, input byte_t exp[$]);
        int bad = -1;
        n_checks++;
        if (mon_q.size() !== exp.size())
            $display("FAIL %s_len got %0d exp %0d", name, mon_q.size(), exp.size());
        else n_pass++;
        for (int i = 0; i < exp.size() && i < mon_q.size(); i++)
            if (bad < 0 && mon_q[i] !== exp[i]) bad = i;
        n_checks++;
        if (bad >= 0)
            $display("FAIL %s_byte%0d got %h exp %h", name, bad, mon_q[bad], exp[bad]);
        else n_pass++;
    endtask

    task automatic run_frame(input string name, input logic [RESP_W-1:0] resp, input bit rnd);
        byte_t exp[$];
        bit    ok;
        model_frame(resp, exp);
        mon_q.delete();
        offer(resp, ok);
        n_checks++;
        if (!ok) begin
            $display("FAIL %s_capture_timeout got ready=0 exp ready=1", name);
            return;
        end
        n_pass++;
        collect(exp.size(), rnd, ok);
        n_checks++;
        if (!ok) $display("FAIL %s_timeout got %0d bytes exp %0d", name, mon_q.size(), exp.size());
        else n_pass++;
        check_frame(name, exp);
        commit(resp);
        n_checks++;
        if (frame_cnt !== 8'(m_frame_cnt))
            $display("FAIL %s_frame_cnt got %0d exp %0d", name, frame_cnt, m_frame_cnt);
        else n_pass++;
        n_checks++;
        if (bus_if.tx_valid !== 1'b0 || busy !== 1'b0)
            $display("FAIL %s_idle_gap got valid=%b busy=%b exp 0 0", name, bus_if.tx_valid, busy);
        else n_pass++;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus_if.resp_valid = 1'b0;
        bus_if.resp_data  = '0;
        bus_if.tx_ready   = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        n_checks++;
        if (bus_if.resp_ready !== 1'b1) $display("FAIL rst_resp_ready got %b exp 1", bus_if.resp_ready);
        else n_pass++;
        n_checks++;
        if (bus_if.tx_valid !== 1'b0) $display("FAIL rst_tx_valid got %b exp 0", bus_if.tx_valid);
        else n_pass++;
        n_checks++;
        if (bus_if.tx_data !== 8'h00) $display("FAIL rst_tx_data got %h exp 00", bus_if.tx_data);
        else n_pass++;
        n_checks++;
        if (busy !== 1'b0) $display("FAIL rst_busy got %b exp 0", busy);
        else n_pass++;
        n_checks++;
        if (frame_cnt !== 8'd0) $display("FAIL rst_frame_cnt got %0d exp 0", frame_cnt);
        else n_pass++;
    endtask

    task automatic test_zero_frame();
        byte_t acc = 8'h00;
        run_frame("zero", '0, 1'b0);
        for (int i = 1; i < mon_q.size(); i++) acc |= mon_q[i];
        n_checks++;
        if (mon_q.size() !== EXP_LEN || acc !== 8'h00 || frame_cnt !== 8'd1)
            $display("FAIL zero_literal got len=%0d or=%h cnt=%0d exp len=%0d or=00 cnt=1",
                     mon_q.size(), acc, frame_cnt, EXP_LEN);
        else n_pass++;
    endtask

    task automatic test_ones_frame();
        byte_t exp_csum;
`ifdef HD_APPEND_EN
        exp_csum = 8'h81;
`else
        exp_csum = 8'h01;
`endif
        run_frame("ones", '1, 1'b0);
        n_checks++;
        if (mon_q.size() != EXP_LEN || mon_q[1] !== 8'h01 || mon_q[EXP_LEN-1] !== exp_csum)
            $display("FAIL ones_literal got idx=%h csum=%h exp idx=01 csum=%h",
                     mon_q[1], mon_q[mon_q.size()-1], exp_csum);
        else n_pass++;
`ifdef HD_APPEND_EN
        n_checks++;
        if (mon_q.size() != EXP_LEN || mon_q[EXP_LEN-2] !== 8'h80)
            $display("FAIL ones_hd got %h exp 80", mon_q[mon_q.size()-2]);
        else n_pass++;
`endif
    endtask

    task automatic test_backpressure();
        logic [RESP_W-1:0] r = rand_resp();
        byte_t exp[$];
        bit    ok;
        model_frame(r, exp);
        mon_q.delete();
        offer(r, ok);
        collect(2, 1'b0, ok);
        bus_if.tx_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            n_checks++;
            if (bus_if.tx_valid !== 1'b1 || bus_if.tx_data !== exp[2] || mon_q.size() != 2)
                $display("FAIL bp_hold%0d got valid=%b data=%h n=%0d exp valid=1 data=%h n=2",
                         i, bus_if.tx_valid, bus_if.tx_data, mon_q.size(), exp[2]);
            else n_pass++;
        end
        collect(exp.size(), 1'b0, ok);
        check_frame("bp", exp);
        commit(r);
    endtask

    task automatic test_mid_frame_offer();
        logic [RESP_W-1:0] ra = rand_resp();
        logic [RESP_W-1:0] rb = rand_resp();
        byte_t exp[$];
        bit    ok;
        model_frame(ra, exp);
        mon_q.delete();
        offer(ra, ok);
        collect(5, 1'b0, ok);
        bus_if.resp_data  = rb;
        bus_if.resp_valid = 1'b1;
        n_checks++;
        if (bus_if.resp_ready !== 1'b0 || busy !== 1'b1)
            $display("FAIL mid_ready got ready=%b busy=%b exp 0 1", bus_if.resp_ready, busy);
        else n_pass++;
        collect(exp.size(), 1'b0, ok);
        check_frame("mid_a", exp);
        commit(ra);
        run_frame("mid_b", rb, 1'b0);
    endtask

    task automatic test_reset_mid_frame();
        logic [RESP_W-1:0] r = rand_resp();
        bit ok;
        mon_q.delete();
        offer(r, ok);
        collect(6, 1'b0, ok);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
        n_checks++;
        if (bus_if.tx_valid !== 1'b0 || bus_if.resp_ready !== 1'b1 || frame_cnt !== 8'd0 || busy !== 1'b0)
            $display("FAIL rstmid_state got valid=%b ready=%b cnt=%0d busy=%b exp 0 1 0 0",
                     bus_if.tx_valid, bus_if.resp_ready, frame_cnt, busy);
        else n_pass++;
        n_checks++;
        if (mon_q.size() != 6) $display("FAIL rstmid_no_xfer got %0d exp 6", mon_q.size());
        else n_pass++;
        run_frame("rstmid_next", rand_resp(), 1'b0);
        n_checks++;
        if (mon_q.size() < 2 || mon_q[1] !== 8'h00)
            $display("FAIL rstmid_idx got %h exp 00", mon_q.size() > 1 ? mon_q[1] : 8'hxx);
        else n_pass++;
    endtask

    task automatic test_random();
        logic [RESP_W-1:0] r;
        for (int i = 0; i < 8; i++) begin
            r = rand_resp();
            if (i % 2 == 1) r = m_prev ^ (RESP_W'(1) << $urandom_range(0, RESP_W - 1));
            run_frame("rand", r, 1'b1);
        end
    endtask

    task automatic test_back_to_back();
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
        bus_if.tx_ready = 1'b1;
        for (int i = 0; i < 257; i++) begin
            run_frame("b2b", rand_resp(), 1'b0);
            if (i >= 254) begin
                n_checks++;
                if (mon_q.size() < 2 || mon_q[1] !== 8'(i))
                    $display("FAIL b2b_idx%0d got %h exp %h", i, mon_q.size() > 1 ? mon_q[1] : 8'hxx, 8'(i));
                else n_pass++;
            end
        end
        n_checks++;
        if (frame_cnt !== 8'd1) $display("FAIL b2b_wrap got %0d exp 1", frame_cnt);
        else n_pass++;
    endtask

    initial begin
        #3ms;
        $display("FAIL watchdog got timeout exp completion");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_zero_frame();
        test_ones_frame();
        test_backpressure();
        test_mid_frame_offer();
        test_reset_mid_frame();
        test_random();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
